// File: rtl/prog_mem_ctrl_if.sv
// Fetch and load port bundle for the program memory controller.
// The master side is the PC / boot source; the slave side is the controller.
interface prog_mem_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);

  // Fetch port
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;

  // Load port
  logic              load_start;
  logic              load_byte_valid;
  logic [DATA_W-1:0] load_byte;
  logic              load_end;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_count;

  modport master (
    output fetch_req, fetch_addr, load_start, load_byte_valid, load_byte, load_end,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault, load_busy, load_done, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_byte_valid, load_byte, load_end,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault, load_busy, load_done, load_count
  );

endinterface

// File: rtl/prog_mem_ctrl.sv
// Program memory with a registered one-cycle fetch port and a byte-stream load port.
// Fetches are served only in IDLE; a load session owns the array while LOADING.
module prog_mem_ctrl #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic            clk,
  input logic            reset,
  prog_mem_ctrl_if.slave bus
);

  localparam int unsigned   IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth held one bit wider than the address so DEPTH = 2^ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StLoading
  } state_e;

  state_e state_q, state_d;

  // Power-up contents are NOP_WORD; reset deliberately leaves the array alone.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_fault_q;
  logic              load_done_q;
  logic [ADDR_W:0]   load_count_q;   // doubles as the write pointer

  logic fetch_accept;
  logic addr_in_range;
  logic load_write;
  logic load_last;

  // Decode handshake qualifiers from the current state and inputs
  always_comb begin
    fetch_accept  = bus.fetch_req && (state_q == StIdle);
    addr_in_range = ({1'b0, bus.fetch_addr} < DEPTH_L);
    load_write    = bus.load_byte_valid && (state_q == StLoading);
    load_last     = (load_count_q == LAST_L);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the write to the last word closes the session by itself
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load_start) state_d = StLoading;
      end
      StLoading: begin
        if (bus.load_end || (load_write && load_last)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: status decoded from the state register, the rest from registers
  always_comb begin
    bus.fetch_ready = (state_q == StIdle);
    bus.load_busy   = (state_q == StLoading);
    bus.fetch_valid = fetch_valid_q;
    bus.fetch_data  = fetch_data_q;
    bus.fetch_fault = fetch_fault_q;
    bus.load_done   = load_done_q;
    bus.load_count  = load_count_q;
  end

  // Array write port; no writes while reset is asserted
  always_ff @(posedge clk) begin
    if (load_write && !reset) begin
      mem_q[load_count_q[IDX_W-1:0]] <= bus.load_byte;
    end
  end

  // Registered fetch; out-of-range addresses return NOP_WORD with a fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= NOP_WORD;
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_accept;
      if (fetch_accept) begin
        if (addr_in_range) begin
          fetch_data_q  <= mem_q[bus.fetch_addr[IDX_W-1:0]];
          fetch_fault_q <= 1'b0;
        end else begin
          fetch_data_q  <= NOP_WORD;
          fetch_fault_q <= 1'b1;
        end
      end
    end
  end

  // Load session counter and done pulse; reset drops the pulse of an aborted session
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= (state_q == StLoading) && (state_d == StIdle);
      if ((state_q == StIdle) && bus.load_start) begin
        load_count_q <= '0;
      end else if (load_write) begin
        load_count_q <= load_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Directed bench for prog_mem_ctrl: loop sequences for power-up and full load,
// then a per-cycle vector table for range, collision, early-end and reset cases.
module tb_prog_mem_ctrl;

  logic clk = 1'b0;
  logic reset;

  prog_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  prog_mem_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .DEPTH   (32),
    .NOP_WORD(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] addr;
    logic       ls;
    logic       bv;
    logic [7:0] b;
    logic       le;
    logic       ev;
    logic [7:0] ed;
    logic       ef;
    logic       er;
    logic       eb;
    logic       edn;
    logic [8:0] ec;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] img [32];

  function automatic vec_t mk(input logic rst, input logic req, input logic [7:0] addr,
                              input logic ls, input logic bv, input logic [7:0] b,
                              input logic le, input logic ev, input logic [7:0] ed,
                              input logic ef, input logic er, input logic eb,
                              input logic edn, input logic [8:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.ls = ls; v.bv = bv; v.b = b; v.le = le;
    v.ev = ev; v.ed = ed; v.ef = ef; v.er = er; v.eb = eb; v.edn = edn; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [7:0] addr, input logic ls,
                       input logic bv, input logic [7:0] b, input logic le);
    bus.fetch_req       = req;
    bus.fetch_addr      = addr;
    bus.load_start      = ls;
    bus.load_byte_valid = bv;
    bus.load_byte       = b;
    bus.load_end        = le;
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int done_cnt;

  initial begin
    for (int i = 0; i < 32; i++) img[i] = 8'(8'h10 + i);
    img[0] = 8'h05; img[1] = 8'h07; img[2] = 8'h02;
    img[3] = 8'h06; img[4] = 8'h0C; img[5] = 8'h03;

    // ---- Reset state ----
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    chk("rst_valid", 0, 32'(bus.fetch_valid), 32'd0);
    chk("rst_fault", 0, 32'(bus.fetch_fault), 32'd0);
    chk("rst_data",  0, 32'(bus.fetch_data),  32'h00);
    chk("rst_busy",  0, 32'(bus.load_busy),   32'd0);
    chk("rst_done",  0, 32'(bus.load_done),   32'd0);
    chk("rst_count", 0, 32'(bus.load_count),  32'd0);
    chk("rst_ready", 0, 32'(bus.fetch_ready), 32'd1);
    reset = 1'b0;

    // ---- Power-up sweep: one result per cycle, each one cycle after its request ----
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 8'(a), 1'b0, 1'b0, 8'h00, 1'b0);
      cyc();
      chk("pwr_valid", a, 32'(bus.fetch_valid), 32'd1);
      chk("pwr_data",  a, 32'(bus.fetch_data),  32'h00);
      chk("pwr_fault", a, 32'(bus.fetch_fault), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("pwr_idle_valid", 0, 32'(bus.fetch_valid), 32'd0);

    // ---- Full load with 0..3 cycle gaps, auto-terminated at word 31 ----
    done_cnt = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("full_busy_start", 0, 32'(bus.load_busy), 32'd1);
    chk("full_ready_start", 0, 32'(bus.fetch_ready), 32'd0);
    for (int i = 0; i < 32; i++) begin
      for (int g = 0; g < (i % 4); g++) begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        chk("full_gap_busy", i, 32'(bus.load_busy), 32'd1);
        if (bus.load_done) done_cnt++;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, img[i], 1'b0);
      cyc();
      if (bus.load_done) done_cnt++;
      chk("full_count", i, 32'(bus.load_count), 32'(i + 1));
      chk("full_busy", i, 32'(bus.load_busy), (i == 31) ? 32'd0 : 32'd1);
    end
    // Byte offered after the auto-end must be dropped
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    cyc();
    if (bus.load_done) done_cnt++;
    chk("full_done_pulses", 0, 32'(done_cnt), 32'd1);
    chk("full_count_final", 0, 32'(bus.load_count), 32'd32);
    chk("full_ready_after", 0, 32'(bus.fetch_ready), 32'd1);
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 8'(a), 1'b0, 1'b0, 8'h00, 1'b0);
      cyc();
      chk("rd_valid", a, 32'(bus.fetch_valid), 32'd1);
      chk("rd_data",  a, 32'(bus.fetch_data),  32'(img[a]));
    end

    // ---- Per-cycle vector table ----
    //                rst  req  addr   ls   bv   b      le   ev   ed     ef   er   eb   edn  ec
    // out of range
    tbl.push_back(mk(0,   1,   8'd32,  0,   0,   8'h00, 0,   1,   8'h00, 1,   1,   0,   0,   32));
    tbl.push_back(mk(0,   1,   8'd255, 0,   0,   8'h00, 0,   1,   8'h00, 1,   1,   0,   0,   32));
    tbl.push_back(mk(0,   1,   8'd31,  0,   0,   8'h00, 0,   1,   8'h2F, 0,   1,   0,   0,   32));
    // collision: fetch with load_start reads old word, fetch while loading dropped
    tbl.push_back(mk(0,   1,   8'd1,   1,   0,   8'h00, 0,   1,   8'h07, 0,   0,   1,   0,   0));
    tbl.push_back(mk(0,   1,   8'd0,   0,   1,   8'hA1, 0,   0,   8'h07, 0,   0,   1,   0,   1));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hB2, 1,   0,   8'h07, 0,   1,   0,   1,   2));
    tbl.push_back(mk(0,   0,   8'd0,   0,   0,   8'h00, 0,   0,   8'h07, 0,   1,   0,   0,   2));
    tbl.push_back(mk(0,   1,   8'd1,   0,   0,   8'h00, 0,   1,   8'hB2, 0,   1,   0,   0,   2));
    tbl.push_back(mk(0,   1,   8'd0,   0,   0,   8'h00, 0,   1,   8'hA1, 0,   1,   0,   0,   2));
    tbl.push_back(mk(0,   1,   8'd40,  0,   0,   8'h00, 0,   1,   8'h00, 1,   1,   0,   0,   2));
    // early end: 3 bytes with a gap, load_end on the third
    tbl.push_back(mk(0,   0,   8'd0,   1,   0,   8'h00, 0,   0,   8'h00, 0,   0,   1,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hC1, 0,   0,   8'h00, 0,   0,   1,   0,   1));
    tbl.push_back(mk(0,   0,   8'd0,   0,   0,   8'h00, 0,   0,   8'h00, 0,   0,   1,   0,   1));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hC2, 0,   0,   8'h00, 0,   0,   1,   0,   2));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hC3, 1,   0,   8'h00, 0,   1,   0,   1,   3));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hEE, 1,   0,   8'h00, 0,   1,   0,   0,   3));
    tbl.push_back(mk(0,   1,   8'd2,   0,   0,   8'h00, 0,   1,   8'hC3, 0,   1,   0,   0,   3));
    tbl.push_back(mk(0,   1,   8'd3,   0,   0,   8'h00, 0,   1,   8'h06, 0,   1,   0,   0,   3));
    tbl.push_back(mk(0,   1,   8'd0,   0,   0,   8'h00, 0,   1,   8'hC1, 0,   1,   0,   0,   3));
    // load_start during LOADING is ignored
    tbl.push_back(mk(0,   0,   8'd0,   1,   0,   8'h00, 0,   0,   8'hC1, 0,   0,   1,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hD1, 0,   0,   8'hC1, 0,   0,   1,   0,   1));
    tbl.push_back(mk(0,   0,   8'd0,   1,   1,   8'hD2, 0,   0,   8'hC1, 0,   0,   1,   0,   2));
    tbl.push_back(mk(0,   0,   8'd0,   0,   0,   8'h00, 1,   0,   8'hC1, 0,   1,   0,   1,   2));
    // reset mid-load after 2 bytes
    tbl.push_back(mk(0,   0,   8'd0,   1,   0,   8'h00, 0,   0,   8'hC1, 0,   0,   1,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hE0, 0,   0,   8'hC1, 0,   0,   1,   0,   1));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hE1, 0,   0,   8'hC1, 0,   0,   1,   0,   2));
    tbl.push_back(mk(1,   0,   8'd0,   0,   0,   8'h00, 0,   0,   8'h00, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   0,   8'h00, 0,   0,   8'h00, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   1,   8'hE3, 0,   0,   8'h00, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   1,   8'd0,   0,   0,   8'h00, 0,   1,   8'hE0, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   1,   8'd1,   0,   0,   8'h00, 0,   1,   8'hE1, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   1,   8'd2,   0,   0,   8'h00, 0,   1,   8'hC3, 0,   1,   0,   0,   0));
    tbl.push_back(mk(0,   0,   8'd0,   0,   0,   8'h00, 0,   0,   8'hC3, 0,   1,   0,   0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].req, tbl[i].addr, tbl[i].ls, tbl[i].bv, tbl[i].b, tbl[i].le);
      cyc();
      chk("tbl_valid", i, 32'(bus.fetch_valid), 32'(tbl[i].ev));
      chk("tbl_data",  i, 32'(bus.fetch_data),  32'(tbl[i].ed));
      if (tbl[i].ev) chk("tbl_fault", i, 32'(bus.fetch_fault), 32'(tbl[i].ef));
      chk("tbl_ready", i, 32'(bus.fetch_ready), 32'(tbl[i].er));
      chk("tbl_busy",  i, 32'(bus.load_busy),   32'(tbl[i].eb));
      chk("tbl_done",  i, 32'(bus.load_done),   32'(tbl[i].edn));
      chk("tbl_count", i, 32'(bus.load_count),  32'(tbl[i].ec));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
